// File: rtl/arp_rx.sv
// ARP receive parser: checks preamble, MAC/EtherType and ARP target IP, then reports sender MAC/IP.
// arp_rx_done pulses one cycle after ARP byte 27 is sampled; GMII stream, no backpressure.
module arp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_00_02        // 192.168.0.2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  typedef enum logic [4:0] {
    st_idle     = 5'b00001,
    st_preamble = 5'b00010,
    st_eth_head = 5'b00100,
    st_arp_data = 5'b01000,
    st_rx_end   = 5'b10000
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        armed;
  logic        hit;
  logic [47:0] dmac_r;
  logic [7:0]  etype_hi;
  logic [15:0] opcode_r;
  logic [47:0] smac_r;
  logic [31:0] sip_r;
  logic [23:0] tip_r;

  logic head_ok;
  logic arp_ok;

  // Decisions use the last byte of the field straight off the wire.
  assign head_ok = ((dmac_r == BOARD_MAC) || (dmac_r == 48'hFF_FF_FF_FF_FF_FF)) &&
                   ({etype_hi, gmii_rxd} == 16'h0806);
  assign arp_ok  = ((opcode_r == 16'd1) || (opcode_r == 16'd2)) &&
                   ({tip_r, gmii_rxd} == BOARD_IP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= st_idle;
      cnt         <= 5'd0;
      armed       <= 1'b0;
      hit         <= 1'b0;
      dmac_r      <= 48'd0;
      etype_hi    <= 8'd0;
      opcode_r    <= 16'd0;
      smac_r      <= 48'd0;
      sip_r       <= 32'd0;
      tip_r       <= 24'd0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= 48'd0;
      src_ip      <= 32'd0;
    end else begin
      arp_rx_done <= 1'b0;
      // A frame cut short by reset must end (dv low) before a new preamble is accepted.
      if (!gmii_rx_dv)
        armed <= 1'b1;

      case (state)
        st_idle: begin
          cnt <= 5'd0;
          if (gmii_rx_dv && armed && (gmii_rxd == 8'h55))
            state <= st_preamble;
        end

        st_preamble: begin
          if (!gmii_rx_dv) begin
            state <= st_idle;
            cnt   <= 5'd0;
          end else if (cnt < 5'd6) begin
            if (gmii_rxd == 8'h55) begin
              cnt <= cnt + 5'd1;
            end else begin
              state <= st_rx_end;
              cnt   <= 5'd0;
            end
          end else begin
            state <= (gmii_rxd == 8'hD5) ? st_eth_head : st_rx_end;
            cnt   <= 5'd0;
          end
        end

        st_eth_head: begin
          if (!gmii_rx_dv) begin
            state <= st_idle;
            cnt   <= 5'd0;
          end else begin
            if (cnt < 5'd6)
              dmac_r <= {dmac_r[39:0], gmii_rxd};
            if (cnt == 5'd12)
              etype_hi <= gmii_rxd;
            if (cnt == 5'd13) begin
              state <= head_ok ? st_arp_data : st_rx_end;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end

        st_arp_data: begin
          if (!gmii_rx_dv) begin
            state <= st_idle;
            cnt   <= 5'd0;
          end else begin
            if (cnt == 5'd6 || cnt == 5'd7)
              opcode_r <= {opcode_r[7:0], gmii_rxd};
            if (cnt >= 5'd8 && cnt <= 5'd13)
              smac_r <= {smac_r[39:0], gmii_rxd};
            if (cnt >= 5'd14 && cnt <= 5'd17)
              sip_r <= {sip_r[23:0], gmii_rxd};
            if (cnt >= 5'd24 && cnt <= 5'd26)
              tip_r <= {tip_r[15:0], gmii_rxd};
            if (cnt == 5'd27) begin
              hit   <= arp_ok;
              state <= st_rx_end;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end

        st_rx_end: begin
          cnt <= 5'd0;
          if (hit) begin
            hit         <= 1'b0;
            arp_rx_done <= 1'b1;
            arp_rx_type <= (opcode_r == 16'd2);
            src_mac     <= smac_r;
            src_ip      <= sip_r;
          end
          if (!gmii_rx_dv)
            state <= st_idle;
        end

        default: begin
          state <= st_idle;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/arp_rx.md
ARP_RX -- requirements
Module: arp_rx

Interface
REQ-001 BOARD_MAC, default 48'h00_11_22_33_44_55, local MAC address for destination-MAC matching.
REQ-002 BOARD_IP, default 192.168.0.2, local IP address for ARP target-IP matching.
REQ-003 clk  input  1  GMII receive clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 gmii_rx_dv  input  1  GMII receive data valid.
REQ-006 gmii_rxd  input  8  GMII receive byte, sampled when gmii_rx_dv=1.
REQ-007 arp_rx_done  output  1  one-cycle pulse: valid ARP frame for this board parsed.
REQ-008 arp_rx_type  output  1  0 = ARP request (opcode 1), 1 = ARP reply (opcode 2).
REQ-009 src_mac  output  48  sender hardware address from the ARP payload.
REQ-010 src_ip  output  32  sender protocol address from the ARP payload.

Function
REQ-011 The block SHALL be a one-hot FSM with states st_idle, st_preamble, st_eth_head, st_arp_data, st_rx_end, and an internal byte counter.
REQ-012 st_idle: on the first cycle with gmii_rx_dv=1 and gmii_rxd=8'h55, the block SHALL count that byte as preamble byte 0 and go to st_preamble; other bytes SHALL be ignored.
REQ-013 st_preamble: the block SHALL require six more 8'h55 bytes followed by 8'hD5, then go to st_eth_head; any mismatch SHALL go to st_rx_end.
REQ-014 st_eth_head: 14 bytes SHALL be parsed.
  - Bytes 0-5: destination MAC; must equal BOARD_MAC or 48'hFF_FF_FF_FF_FF_FF.
  - Bytes 12-13: EtherType; must equal 16'h0806.
  - On failure the block SHALL go to st_rx_end after byte 13; on pass, to st_arp_data.
REQ-015 st_arp_data: 28 bytes SHALL be parsed, with fields captured into internal registers.
  - Bytes 6-7: opcode.
  - Bytes 8-13: sender MAC.
  - Bytes 14-17: sender IP.
  - Bytes 24-27: target IP.
REQ-016 After ARP byte 27, if opcode is 1 or 2 and target IP equals BOARD_IP, then on the next rising edge the block SHALL:
  - assert arp_rx_done for exactly one cycle;
  - update src_mac, src_ip and arp_rx_type in the same cycle;
  - go to st_rx_end.
  Otherwise it SHALL go to st_rx_end with no output change.
REQ-017 Padding and FCS bytes after ARP byte 27 SHALL be consumed in st_rx_end; FCS is not checked.
REQ-018 st_rx_end SHALL return to st_idle on the first cycle with gmii_rx_dv=0.
REQ-019 gmii_rx_dv=0 in st_preamble, st_eth_head or st_arp_data SHALL return the FSM to st_idle, with no done pulse and no output update.
REQ-020 src_mac, src_ip and arp_rx_type SHALL hold their values between valid frames; a rejected frame SHALL NOT alter them.
REQ-021 Latency: arp_rx_done SHALL rise on the clock edge following the edge that samples ARP byte 27.
REQ-022 Frames arriving back-to-back with a single dv-low gap cycle SHALL both be parsed.
REQ-023 The byte counter SHALL reset to 0 on every state transition and never wrap within a state.

Reset
REQ-024 While rst_n=0, the block SHALL hold: state st_idle, counter 0, arp_rx_done=0, arp_rx_type=0, src_mac=0, src_ip=0, all capture registers 0.
REQ-025 rst_n asserted mid-frame SHALL abort the frame immediately; after release, the block SHALL wait in st_idle for a fresh preamble (remaining bytes of the aborted frame ignored until dv low, then a new 8'h55).

Verification
REQ-026 Broadcast ARP request: sender MAC 00:0A:35:01:02:03, sender IP 192.168.0.3, target IP 192.168.0.2 -> one arp_rx_done pulse; arp_rx_type=0; src_mac=48'h000A35010203; src_ip=32'hC0A80003.
REQ-027 Unicast ARP reply: destination MAC = BOARD_MAC, opcode 2 -> arp_rx_done pulse; arp_rx_type=1.
REQ-028 Target IP 192.168.0.9 or EtherType 16'h0800 -> no pulse; outputs keep their prior values.
REQ-029 gmii_rx_dv dropped at ARP byte 10 -> no pulse; the next valid frame is received correctly.
REQ-030 rst_n pulsed low at header byte 5 -> all outputs 0 immediately; the following full frame yields a correct pulse.
REQ-031 Bad preamble (byte 3 = 8'h54) -> no pulse; the block recovers for the next frame after dv low.
